alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter sharing one 64-bit ALU instance (AND/OR/ADD, zero flag, carry-out) between two requesters, e.g. the pipeline execute stage and an address-generation/auxiliary unit. Each requester issues operand/opcode packets over a valid/ready handshake. The arbiter registers the granted operands, drives the shared ALU for one cycle, captures result and flags, and returns them on the requester's own response channel. One operation is in flight at a time.

## Interface
- WIDTH, 64, operand/result width; must match the ALU instance.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- reqN_valid  in  1  (N=0,1) requester N presents an operation.
- reqN_ready  out  1  arbiter accepts requester N's operation this cycle.
- reqN_a, reqN_b  in  WIDTH  operands.
- reqN_sel  in  4  ALU opcode: 0000 AND, 0001 OR, 0010 ADD, other → result 0.
- alu_a, alu_b  out  WIDTH  to shared ALU A/B (registered).
- alu_sel  out  4  to shared ALU select (registered).
- alu_out  in  WIDTH  ALU result.
- alu_cout, alu_z  in  1  ALU carry-out and zero flag.
- rspN_valid  out  1  result for requester N available.
- rspN_ready  in  1  requester N consumes the result.
- rsp_result  out  WIDTH  captured result (shared by both response channels).
- rsp_cout, rsp_z  out  1  captured carry-out / zero flag.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: grant computed combinationally from reqN_valid and last_grant:
  - only one valid → grant it; both valid → grant requester != last_grant; none → stay IDLE.
  - reqN_ready = (state==IDLE) && grant==N; at most one ready high per cycle.
  - On valid&&ready: latch a, b, sel into alu_a/alu_b/alu_sel, store owner=N, last_grant←N, go EXEC.
- EXEC: ALU sees stable registered inputs; at clock edge capture alu_out/alu_cout/alu_z into rsp_result/rsp_cout/rsp_z; go RESP.
- RESP: rsp{owner}_valid=1, other rsp valid=0. Hold result stable until rsp{owner}_ready=1; on that edge go IDLE.
- alu_a/alu_b/alu_sel hold last accepted values outside EXEC (no re-zeroing).
- Arbiter does not decode sel; unsupported opcodes yield whatever the ALU returns (result 0, z=1, cout = adder carry of A+B).
- Requester rules: once reqN_valid is high, payload and valid must stay stable until reqN_ready; arbiter samples only on valid&&ready.
- No reqN_ready during EXEC/RESP, even if the other requester is idle (strictly one in flight).
- Starvation-free: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, last_grant=1 (requester 0 wins first contest), owner=0, alu_a=alu_b=0, alu_sel=0000, rsp_result=0, rsp_cout=0, rsp_z=0, rsp0_valid=rsp1_valid=0. reqN_ready may go high in the first cycle after release only via the IDLE grant logic.
- Accept at edge ending cycle T → EXEC in T+1 → rspN_valid high in T+2.
- If rspN_ready high in T+2, IDLE in T+3; next accept possible in T+3. Minimum 3 cycles per operation.
- Reset asserted mid-operation (EXEC or RESP): in-flight op is discarded, no response issued; requester must reissue.
- rspN_ready asserted while rspN_valid low is ignored.
- Requester dropping valid in IDLE before ready: nothing latched, no state change.

## Test plan
- Reset: hold rst_n low, drive random inputs → all outputs at reset values, both ready/valid low except combinational IDLE grant after release.
- Single ADD: req0 a=5, b=7, sel=0010, rsp0_ready=1 → req0_ready high in T, rsp0_valid in T+2 with result 12, cout 0, z 0; rsp1_valid stays 0.
- Overflow: req1 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 → rsp1 result 0, cout 1, z 1.
- Contention: both valid from reset, req0 AND 0xF0/0x3C, req1 OR 0xF0/0x0F, held for 4 ops → grant order 0,1,0,1; results 0x30 and 0xFF; accepts spaced exactly 3 cycles.
- Backpressure: rsp1_ready low 5 cycles with req0_valid high → rsp1_valid, rsp_result stable; req0_ready stays 0; req0 accepted the cycle after rsp1 handshake completes.
- Reset mid-EXEC: pulse rst_n low during EXEC → no rsp valid, state IDLE, next contention granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter in front of one shared ALU.
// Accepts one operand/opcode packet at a time from req0/req1 (valid/ready),
// drives the registered operands to the ALU for one cycle, captures the
// result and flags, and returns them on the owning requester's rsp channel.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready/a/b/sel   requester N operation channel (N=0,1)
//   alu_a/alu_b/alu_sel        registered operands/opcode to the shared ALU
//   alu_out/alu_cout/alu_z     ALU result and flags
//   rspN_valid/ready           requester N response handshake
//   rsp_result/rsp_cout/rsp_z  captured result shared by both rsp channels
module alu_arbiter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             alu_z,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;

    logic grant_c;
    logic accept_c;
    logic rsp_done_c;

    // Round-robin grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant_q;
        end else begin
            grant_c = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant_c;
    assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_c;
    assign accept_c   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign rsp_done_c = owner_q ? (rsp1_valid_q && rsp1_ready)
                                : (rsp0_valid_q && rsp0_ready);

    // Next-state and datapath capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_z_d      = rsp_z_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    owner_d      = grant_c;
                    last_grant_d = grant_c;
                    alu_a_d      = grant_c ? req1_a   : req0_a;
                    alu_b_d      = grant_c ? req1_b   : req0_b;
                    alu_sel_d    = grant_c ? req1_sel : req0_sel;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_out;
                rsp_cout_d   = alu_cout;
                rsp_z_d      = alu_z;
                rsp0_valid_d = !owner_q;
                rsp1_valid_d = owner_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_done_c) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and datapath registers; last_grant resets to 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 4'b0000;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_z_q      <= rsp_z_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_z      = rsp_z_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: behavioural shared ALU, scoreboard of expected
// responses pushed on accept and popped on response handshake.
module tb_alu_arbiter;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_sel, req1_sel;
    logic [W-1:0] alu_a, alu_b, alu_out, rsp_result;
    logic [3:0]   alu_sel;
    logic         alu_cout, alu_z;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic         rsp_cout, rsp_z;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic         owner;
        logic [W-1:0] res;
        logic         cout;
        logic         z;
        int           acc_cyc;
    } item_t;

    item_t sb[$];
    logic  grant_log[$];
    int    acc_log[$];
    logic  rsp_seen = 1'b0;
    item_t it;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_z(alu_z),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_z(rsp_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected ALU behaviour for a requester payload.
    function automatic item_t model(logic o, logic [W-1:0] a, logic [W-1:0] b,
                                    logic [3:0] s, int c);
        item_t r;
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        r.owner = o;
        r.acc_cyc = c;
        case (s)
            4'b0000: begin r.res = a & b;       r.cout = 1'b0;   end
            4'b0001: begin r.res = a | b;       r.cout = 1'b0;   end
            4'b0010: begin r.res = sum[W-1:0];  r.cout = sum[W]; end
            default: begin r.res = '0;          r.cout = sum[W]; end
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    // Shared ALU instance seen by the arbiter.
    always_comb begin
        logic [W:0] s;
        s = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_sel)
            4'b0000: begin alu_out = alu_a & alu_b; alu_cout = 1'b0; end
            4'b0001: begin alu_out = alu_a | alu_b; alu_cout = 1'b0; end
            4'b0010: begin alu_out = s[W-1:0];      alu_cout = s[W]; end
            default: begin alu_out = '0;            alu_cout = s[W]; end
        endcase
        alu_z = (alu_out == '0);
    end

    // Monitor: scoreboard push on accept, latency/owner/data check on response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid || rsp1_valid) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_unexpected: rsp0_valid=%0b rsp1_valid=%0b with nothing pending (cycle %0d)",
                             rsp0_valid, rsp1_valid, cyc);
                end else begin
                    if (!rsp_seen) begin
                        rsp_seen = 1'b1;
                        n_checks++;
                        if (cyc !== sb[0].acc_cyc + 2) begin
                            n_fail++;
                            $display("FAIL rsp_latency: got cycle %0d, expected %0d", cyc, sb[0].acc_cyc + 2);
                        end
                        n_checks++;
                        if ((rsp0_valid && rsp1_valid) || (rsp1_valid !== sb[0].owner)) begin
                            n_fail++;
                            $display("FAIL rsp_owner: rsp0_valid=%0b rsp1_valid=%0b, expected owner %0d",
                                     rsp0_valid, rsp1_valid, sb[0].owner);
                        end
                    end
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        it = sb.pop_front();
                        rsp_seen = 1'b0;
                        n_checks++;
                        if (rsp_result !== it.res || rsp_cout !== it.cout || rsp_z !== it.z) begin
                            n_fail++;
                            $display("FAIL rsp_data: got result=%h cout=%0b z=%0b, expected result=%h cout=%0b z=%0b",
                                     rsp_result, rsp_cout, rsp_z, it.res, it.cout, it.z);
                        end
                    end
                end
            end
            n_checks++;
            if (req0_ready && req1_ready) begin
                n_fail++;
                $display("FAIL ready_onehot: req0_ready=1 req1_ready=1, expected at most one");
            end
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_a, req0_b, req0_sel, cyc));
                grant_log.push_back(1'b0);
                acc_log.push_back(cyc);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_a, req1_b, req1_sel, cyc));
                grant_log.push_back(1'b1);
                acc_log.push_back(cyc);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || rsp0_valid || rsp1_valid) && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses still pending, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
            req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            req0_sel = 4'($urandom); req1_sel = 4'($urandom);
            rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (alu_a !== '0 || alu_b !== '0 || alu_sel !== 4'b0000 || rsp_result !== '0 ||
                rsp_cout !== 1'b0 || rsp_z !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_values: alu_a=%h alu_b=%h sel=%h res=%h c=%0b z=%0b v=%0b%0b r=%0b%0b, expected all 0",
                         alu_a, alu_b, alu_sel, rsp_result, rsp_cout, rsp_z, rsp0_valid, rsp1_valid,
                         req0_ready, req1_ready);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: req0_ready=%0b rsp0_valid=%0b rsp1_valid=%0b, expected 0",
                     req0_ready, rsp0_valid, rsp1_valid);
        end
    endtask

    task automatic test_single_add();
        @(posedge clk); #1;
        req0_a = 64'd5; req0_b = 64'd7; req0_sel = 4'b0010;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ready: req0_ready=%0b, expected 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp0_valid !== 1'b0 || alu_a !== 64'd5 || alu_b !== 64'd7 || alu_sel !== 4'b0010) begin
            n_fail++;
            $display("FAIL add_exec: rsp0_valid=%0b alu_a=%h alu_b=%h alu_sel=%h, expected 0/5/7/2",
                     rsp0_valid, alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 64'd12 ||
            rsp_cout !== 1'b0 || rsp_z !== 1'b0) begin
            n_fail++;
            $display("FAIL add_resp: v0=%0b v1=%0b result=%h cout=%0b z=%0b, expected 1/0/c/0/0",
                     rsp0_valid, rsp1_valid, rsp_result, rsp_cout, rsp_z);
        end
        @(negedge clk);
        n_checks++;
        if (rsp0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: rsp0_valid=%0b after handshake, expected 0", rsp0_valid);
        end
        drain("add");
    endtask

    task automatic test_overflow();
        @(posedge clk); #1;
        req1_a = 64'hFFFF_FFFF_FFFF_FFFF; req1_b = 64'd1; req1_sel = 4'b0010;
        req1_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_ready: req1_ready=%0b, expected 1", req1_ready);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== '0 ||
            rsp_cout !== 1'b1 || rsp_z !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_resp: v1=%0b v0=%0b result=%h cout=%0b z=%0b, expected 1/0/0/1/1",
                     rsp1_valid, rsp0_valid, rsp_result, rsp_cout, rsp_z);
        end
        drain("ovf");
    endtask

    task automatic test_contention();
        int k;
        rst_n = 1'b0;
        req0_a = 64'hF0; req0_b = 64'h3C; req0_sel = 4'b0000;
        req1_a = 64'hF0; req1_b = 64'h0F; req1_sel = 4'b0001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        sb.delete(); rsp_seen = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        grant_log.delete(); acc_log.delete();
        k = 0;
        while (grant_log.size() < 4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if (grant_log.size() != 4) begin
            n_fail++;
            $display("FAIL cont_count: %0d grants, expected 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (grant_log[i] !== 1'(i % 2)) begin
                    n_fail++;
                    $display("FAIL cont_order: grant %0d went to %0d, expected %0d", i, grant_log[i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (acc_log[i] - acc_log[i-1] != 3) begin
                    n_fail++;
                    $display("FAIL cont_spacing: accept gap %0d cycles, expected 3", acc_log[i] - acc_log[i-1]);
                end
            end
        end
        drain("cont");
    endtask

    task automatic test_backpressure();
        int k;
        logic [W-1:0] exp_res;
        @(posedge clk); #1;
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        req1_a = 64'h1234_0000_0000_0000; req1_b = 64'h0000_0000_0000_5678; req1_sel = 4'b0001;
        exp_res = 64'h1234_0000_0000_5678;
        req1_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!req1_ready && k < 10) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_a = 64'hFF00; req0_b = 64'h0FF0; req0_sel = 4'b0000;
        req0_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!rsp1_valid && k < 10) begin @(negedge clk); k++; end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp1_valid !== 1'b1 || rsp_result !== exp_res || req0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d v1=%0b result=%h req0_ready=%0b, expected 1/%h/0",
                         i, rsp1_valid, rsp_result, req0_ready, exp_res);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b0 || rsp1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_handshake: req0_ready=%0b rsp1_valid=%0b, expected 0/1", req0_ready, rsp1_valid);
        end
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_next_accept: req0_ready=%0b, expected 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drain("bp");
    endtask

    task automatic test_reset_mid_exec();
        int k;
        @(posedge clk); #1;
        req0_a = 64'd100; req0_b = 64'd23; req0_sel = 4'b0010;
        req0_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!req0_ready && k < 10) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete(); rsp_seen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || alu_a !== '0 || rsp_result !== '0) begin
            n_fail++;
            $display("FAIL rst_exec_discard: v0=%0b v1=%0b alu_a=%h result=%h, expected all 0",
                     rsp0_valid, rsp1_valid, alu_a, rsp_result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_a = 64'hAA; req0_b = 64'h0F; req0_sel = 4'b0000;
        req1_a = 64'h11; req1_b = 64'h22; req1_sel = 4'b0010;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_regrant: req0_ready=%0b req1_ready=%0b, expected 1/0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("rst_exec");
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_sel = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_single_add();
        test_overflow();
        test_contention();
        test_backpressure();
        test_reset_mid_exec();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
